// File: rtl/alu_div_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : alu_div_issue_ctrl_if
// Brief  : Execute, writeback and divider-core handshake bundle for the
//          divide issue controller.
// Rev    : 1.0
// ============================================================================
interface alu_div_issue_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ex_valid;
  logic                  ex_ready;
  logic [1:0]            ex_op;
  logic [DATA_WIDTH-1:0] ex_rs1;
  logic [DATA_WIDTH-1:0] ex_rs2;
  logic [4:0]            ex_rd;
  logic                  flush;
  logic                  stall;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  div_req_valid;
  logic                  div_req_ready;
  logic                  div_cancel;
  logic                  div_signed;
  logic [DATA_WIDTH-1:0] div_num1;
  logic [DATA_WIDTH-1:0] div_num2;
  logic                  div_rsp_valid;
  logic                  div_rsp_ready;
  logic [DATA_WIDTH-1:0] div_sq;
  logic [DATA_WIDTH-1:0] div_uq;
  logic [DATA_WIDTH-1:0] div_sr;
  logic [DATA_WIDTH-1:0] div_ur;

  // Controller side
  modport master (
    input  ex_valid, ex_op, ex_rs1, ex_rs2, ex_rd, flush, wb_ready,
           div_req_ready, div_rsp_valid, div_sq, div_uq, div_sr, div_ur,
    output ex_ready, stall, wb_valid, wb_rd, wb_data,
           div_req_valid, div_cancel, div_signed, div_num1, div_num2,
           div_rsp_ready
  );

  // Pipeline / divider-core side
  modport slave (
    output ex_valid, ex_op, ex_rs1, ex_rs2, ex_rd, flush, wb_ready,
           div_req_ready, div_rsp_valid, div_sq, div_uq, div_sr, div_ur,
    input  ex_ready, stall, wb_valid, wb_rd, wb_data,
           div_req_valid, div_cancel, div_signed, div_num1, div_num2,
           div_rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/alu_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : alu_div_issue_ctrl
// Brief  : Issues DIV/DIVU/REM/REMU to the iterative divider, resolves
//          divide-by-zero and signed overflow locally, hands results to WB.
// Rev    : 1.0
// ============================================================================
module alu_div_issue_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_div_issue_ctrl_if.master bus
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_REQ   = 5'b00010,
    S_WAIT  = 5'b00100,
    S_DRAIN = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  localparam logic [DATA_WIDTH-1:0] c_all_ones = '1;
  localparam logic [DATA_WIDTH-1:0] c_min_int  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                r_state;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_rs1;
  logic [DATA_WIDTH-1:0] r_rs2;
  logic [4:0]            r_rd;
  logic [4:0]            r_wb_rd;
  logic [DATA_WIDTH-1:0] r_wb_data;

  logic                  w_div_zero;
  logic                  w_overflow;
  logic [DATA_WIDTH-1:0] w_rsp_sel;

  assign w_div_zero = (bus.ex_rs2 == '0);
  assign w_overflow = ~bus.ex_op[0] && (bus.ex_rs1 == c_min_int) &&
                      (bus.ex_rs2 == c_all_ones);

  always_comb begin
    w_rsp_sel = '0;
    case (r_op)
      2'b00:   w_rsp_sel = bus.div_sq;
      2'b01:   w_rsp_sel = bus.div_uq;
      2'b10:   w_rsp_sel = bus.div_sr;
      default: w_rsp_sel = bus.div_ur;
    endcase
  end

  assign bus.ex_ready      = (r_state == S_IDLE);
  assign bus.stall         = (bus.ex_valid && (r_state == S_IDLE)) ||
                             (r_state == S_REQ) || (r_state == S_WAIT) ||
                             (r_state == S_DONE);
  assign bus.div_req_valid = (r_state == S_REQ);
  assign bus.div_cancel    = bus.flush;
  assign bus.div_rsp_ready = (r_state == S_WAIT) || (r_state == S_DRAIN);
  assign bus.wb_valid      = (r_state == S_DONE);
  assign bus.wb_rd         = r_wb_rd;
  assign bus.wb_data       = r_wb_data;
  assign bus.div_num1      = r_rs1;
  assign bus.div_num2      = r_rs2;
  assign bus.div_signed    = ~r_op[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ex_valid && !bus.flush) begin
            r_op  <= bus.ex_op;
            r_rs1 <= bus.ex_rs1;
            r_rs2 <= bus.ex_rs2;
            r_rd  <= bus.ex_rd;
            // Writes to x0 have no architectural effect, so skip the divider
            if (bus.ex_rd == 5'd0) begin
              r_state <= S_IDLE;
            end else if (w_div_zero) begin
              r_wb_rd   <= bus.ex_rd;
              r_wb_data <= bus.ex_op[1] ? bus.ex_rs1 : c_all_ones;
              r_state   <= S_DONE;
            end else if (w_overflow) begin
              r_wb_rd   <= bus.ex_rd;
              r_wb_data <= bus.ex_op[1] ? '0 : c_min_int;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else if (bus.div_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.div_rsp_valid) begin
            if (bus.flush) begin
              r_state <= S_IDLE;
            end else begin
              r_wb_rd   <= r_rd;
              r_wb_data <= w_rsp_sel;
              r_state   <= S_DONE;
            end
          end else if (bus.flush) begin
            // Divider still owes us a response; swallow it before reissuing
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.div_rsp_valid) begin
            r_state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (bus.flush || bus.wb_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_div_issue_ctrl
// Brief  : Directed scoreboard bench with a behavioural divider-core model.
// Rev    : 1.0
// ============================================================================
module tb_alu_div_issue_ctrl;

  localparam int DW      = 32;
  localparam int DIV_LAT = 33;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   wb_count;
  int   req_count;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wb_exp_t;
  wb_exp_t exp_q[$];

  alu_div_issue_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  alu_div_issue_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural divider core
  logic          dv_busy;
  int            dv_cnt;
  assign bus.div_req_ready = !dv_busy;

  always @(posedge clk) begin
    if (!rst_n) begin
      dv_busy           <= 1'b0;
      dv_cnt            <= 0;
      bus.div_rsp_valid <= 1'b0;
    end else if (!dv_busy) begin
      if (bus.div_req_valid && bus.div_req_ready) begin
        dv_busy    <= 1'b1;
        dv_cnt     <= DIV_LAT;
        req_count  <= req_count + 1;
        bus.div_sq <= $signed(bus.div_num1) / $signed(bus.div_num2);
        bus.div_sr <= $signed(bus.div_num1) % $signed(bus.div_num2);
        bus.div_uq <= bus.div_num1 / bus.div_num2;
        bus.div_ur <= bus.div_num1 % bus.div_num2;
      end
    end else if (dv_cnt != 0) begin
      dv_cnt <= dv_cnt - 1;
    end else if (!bus.div_rsp_valid) begin
      bus.div_rsp_valid <= 1'b1;
    end else if (bus.div_rsp_ready) begin
      bus.div_rsp_valid <= 1'b0;
      dv_busy           <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Writeback monitor: every accepted, unflushed result must match the queue head
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid && bus.wb_ready && !bus.flush) begin
      wb_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected: got rd=%0d data=%0h expected no writeback",
                 bus.wb_rd, bus.wb_data);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
        chk("wb_data", bus.wb_data, e.data);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [4:0] rd);
    @(posedge clk);
    #1;
    bus.ex_op    = op;
    bus.ex_rs1   = a;
    bus.ex_rs2   = b;
    bus.ex_rd    = rd;
    bus.ex_valid = 1'b1;
    @(negedge clk);
    chk("ex_ready_pre", {31'd0, bus.ex_ready}, 32'd1);
    chk("stall_on_valid", {31'd0, bus.stall}, 32'd1);
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ex_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: got timeout expected ex_ready", name);
    end
  endtask

  task automatic wait_sig(input string name, input int which);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((which == 0 && bus.wb_valid) || (which == 1 && bus.div_rsp_ready) ||
          (which == 2 && bus.div_rsp_valid)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: got timeout expected event %0d", name, which);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ex_ready"}, {31'd0, bus.ex_ready}, 32'd1);
    chk({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
    chk({tag, "_wb_valid"}, {31'd0, bus.wb_valid}, 32'd0);
    chk({tag, "_wb_rd"}, {27'd0, bus.wb_rd}, 32'd0);
    chk({tag, "_wb_data"}, bus.wb_data, 32'd0);
    chk({tag, "_req_valid"}, {31'd0, bus.div_req_valid}, 32'd0);
    chk({tag, "_rsp_ready"}, {31'd0, bus.div_rsp_ready}, 32'd0);
    chk({tag, "_cancel"}, {31'd0, bus.div_cancel}, 32'd0);
  endtask

  // Special cases: result at T+1 without any divider request
  task automatic special(input logic [1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [4:0] rd,
                         input logic [DW-1:0] exp, input string name);
    int rc;
    rc = req_count;
    exp_q.push_back('{rd: rd, data: exp});
    issue(op, a, b, rd);
    @(negedge clk);
    chk({name, "_wb_valid_t1"}, {31'd0, bus.wb_valid}, 32'd1);
    chk({name, "_no_req"}, {31'd0, bus.div_req_valid}, 32'd0);
    wait_idle({name, "_idle"});
    chk({name, "_req_count"}, req_count, rc);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    wb_count        = 0;
    req_count       = 0;
    rst_n           = 1'b0;
    bus.ex_valid    = 1'b0;
    bus.ex_op       = 2'b00;
    bus.ex_rs1      = '0;
    bus.ex_rs2      = '0;
    bus.ex_rd       = '0;
    bus.flush       = 1'b0;
    bus.wb_ready    = 1'b1;
    bus.div_sq      = '0;
    bus.div_uq      = '0;
    bus.div_sr      = '0;
    bus.div_ur      = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst");

    // DIV -7/2 through the divider
    exp_q.push_back('{rd: 5'd5, data: 32'hFFFF_FFFD});
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5);
    @(negedge clk);
    chk("div_req_t1", {31'd0, bus.div_req_valid}, 32'd1);
    chk("div_signed", {31'd0, bus.div_signed}, 32'd1);
    wait_idle("div_idle");

    exp_q.push_back('{rd: 5'd6, data: 32'hFFFF_FFFF});
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6);
    wait_idle("rem_idle");

    special(2'b01, 32'h8000_0000, 32'd0, 5'd7, 32'hFFFF_FFFF, "divu0");
    special(2'b11, 32'h8000_0000, 32'd0, 5'd7, 32'h8000_0000, "remu0");
    special(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, "div_ovf");
    special(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, "rem_ovf");

    // DIVU 100/7 with writeback back-pressure
    bus.wb_ready = 1'b0;
    exp_q.push_back('{rd: 5'd12, data: 32'd14});
    issue(2'b01, 32'd100, 32'd7, 5'd12);
    wait_sig("hold_wb", 0);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      chk("hold_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      chk("hold_wb_data", bus.wb_data, 32'd14);
      chk("hold_stall", {31'd0, bus.stall}, 32'd1);
    end
    @(posedge clk);
    #1 bus.wb_ready = 1'b1;
    wait_idle("hold_idle");

    // Flush 10 cycles into WAIT, then drain the orphaned response
    issue(2'b01, 32'd100, 32'd7, 5'd9);
    wait_sig("drain_wait", 1);
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("drain_cancel", {31'd0, bus.div_cancel}, 32'd1);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("drain_stall", {31'd0, bus.stall}, 32'd0);
    chk("drain_rsp_ready", {31'd0, bus.div_rsp_ready}, 32'd1);
    chk("drain_ex_ready", {31'd0, bus.ex_ready}, 32'd0);
    if (!bus.div_rsp_valid) wait_sig("drain_rsp", 2);
    @(negedge clk);
    chk("drain_ex_ready_after", {31'd0, bus.ex_ready}, 32'd1);
    chk("drain_no_wb", {31'd0, bus.wb_valid}, 32'd0);

    // Flush in DONE together with wb_ready: result dropped
    issue(2'b01, 32'd5, 32'd0, 5'd8);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("done_flush_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("done_flush_dropped", {31'd0, bus.wb_valid}, 32'd0);
    chk("done_flush_idle", {31'd0, bus.ex_ready}, 32'd1);

    // Reset in the middle of WAIT
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3);
    wait_sig("rst_wait", 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");

    // rd = x0: accepted and discarded silently
    begin
      int rc;
      rc = req_count;
      issue(2'b00, 32'd10, 32'd2, 5'd0);
      @(negedge clk);
      chk("rd0_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
      chk("rd0_no_req", {31'd0, bus.div_req_valid}, 32'd0);
      repeat (5) @(negedge clk);
      chk("rd0_no_wb", {31'd0, bus.wb_valid}, 32'd0);
      chk("rd0_req_count", req_count, rc);
    end

    chk("queue_empty", exp_q.size(), 32'd0);
    chk("wb_count", wb_count, 32'd7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
